pixel_pair_writer: RTL and testbench

- Capture-side stage directly upstream of the 24-bit-word frame buffer.
- Accepts a stream of 12-bit RGB444 pixels and packs consecutive pairs into one 24-bit word, {RGB0,RGB1}, with the first pixel in bits [23:12].
- Drives the frame buffer's write port (we_a, w_address, w_data) for one full frame per start-of-frame marker.
- Reports frame completion and resynchronisation errors to the control logic.

---
 rtl/pixel_pair_writer.sv | 118 +++++++++++
 tb/tb_pixel_pair_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_pair_writer.sv
// Packs consecutive RGB444 pixels into 24-bit words and drives the frame-buffer
// write port for one frame per start-of-frame marker.
module pixel_pair_writer #(
  parameter int ADDR_W      = 11,
  parameter int FRAME_WORDS = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              sof,
  input  logic              px_valid,
  input  logic [11:0]       px_data,
  output logic              we_a,
  output logic [ADDR_W-1:0] w_address,
  output logic [23:0]       w_data,
  output logic              frame_done,
  output logic              resync_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CAPTURE, FINISH} state_t;

  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(FRAME_WORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              half, half_nxt;
  logic [11:0]       hold, hold_nxt;
  logic              we_nxt, fd_nxt, rerr_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [23:0]       data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      half       <= 1'b0;
      hold       <= '0;
      we_a       <= 1'b0;
      w_address  <= '0;
      w_data     <= '0;
      frame_done <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      half       <= half_nxt;
      hold       <= hold_nxt;
      we_a       <= we_nxt;
      w_address  <= addr_nxt;
      w_data     <= data_nxt;
      frame_done <= fd_nxt;
      resync_err <= rerr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    half_nxt  = half;
    hold_nxt  = hold;
    we_nxt    = 1'b0;
    addr_nxt  = w_address;
    data_nxt  = w_data;
    fd_nxt    = 1'b0;
    rerr_nxt  = resync_err;
    if (!capture_en) rerr_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (sof && capture_en) begin
          state_nxt = CAPTURE;
          cnt_nxt   = '0;
          half_nxt  = 1'b0;
        end
      end
      CAPTURE: begin
        // The completing pixel outranks a coincident sof: the frame finishes
        // and the sof is not treated as a restart.
        if (!capture_en) begin
          state_nxt = IDLE;
          half_nxt  = 1'b0;
        end else if (px_valid && half && cnt == LAST_WORD) begin
          we_nxt    = 1'b1;
          addr_nxt  = cnt[ADDR_W-1:0];
          data_nxt  = {hold, px_data};
          half_nxt  = 1'b0;
          cnt_nxt   = cnt + 1'b1;
          state_nxt = FINISH;
        end else if (sof) begin
          rerr_nxt  = 1'b1;
          cnt_nxt   = '0;
          half_nxt  = 1'b0;
        end else if (px_valid) begin
          if (!half) begin
            hold_nxt = px_data;
            half_nxt = 1'b1;
          end else begin
            we_nxt   = 1'b1;
            addr_nxt = cnt[ADDR_W-1:0];
            data_nxt = {hold, px_data};
            half_nxt = 1'b0;
            cnt_nxt  = cnt + 1'b1;
          end
        end
      end
      FINISH: begin
        // Cycle holding the final write; frame_done follows it.
        fd_nxt    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pixel_pair_writer.sv
// Self-checking bench for pixel_pair_writer: directed scenarios plus a
// randomized run against a queue-based frame model.
module tb_pixel_pair_writer;

  localparam int AW = 3;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          capture_en, sof, px_valid;
  logic [11:0]   px_data;
  logic          we_a, frame_done, resync_err, busy;
  logic [AW-1:0] w_address;
  logic [23:0]   w_data;

  int tests  = 0;
  int failed = 0;

  pixel_pair_writer #(.ADDR_W(AW), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .sof(sof),
    .px_valid(px_valid), .px_data(px_data), .we_a(we_a),
    .w_address(w_address), .w_data(w_data), .frame_done(frame_done),
    .resync_err(resync_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic e, input logic s, input logic v, input logic [11:0] d);
    capture_en = e; sof = s; px_valid = v; px_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    capture_en = 1'b0; sof = 1'b0; px_valid = 1'b0; px_data = '0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    capture_en = 1'b0; sof = 1'b0; px_valid = 1'b0; px_data = '0;
    #12;
    tests++;
    if ({we_a, w_address, w_data, frame_done, resync_err, busy} !== '0) begin
      failed++;
      $display("FAIL reset: we=%b addr=%0d data=%h fd=%b rerr=%b busy=%b, all required 0",
               we_a, w_address, w_data, frame_done, resync_err, busy);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word();
    cyc(1, 1, 0, 12'h000);
    tests++;
    if (busy !== 1'b1 || we_a !== 1'b0) begin
      failed++; $display("FAIL single_sof: busy=%b we=%b, required busy=1 we=0", busy, we_a);
    end
    cyc(1, 0, 1, 12'h123);
    tests++;
    if (we_a !== 1'b0) begin
      failed++; $display("FAIL single_first: we=%b, required 0", we_a);
    end
    cyc(1, 0, 1, 12'h456);
    tests++;
    if (we_a !== 1'b1 || w_address !== 3'd0 || w_data !== 24'h123456 || busy !== 1'b1) begin
      failed++;
      $display("FAIL single_write: we=%b addr=%0d data=%h busy=%b, required 1 0 123456 1",
               we_a, w_address, w_data, busy);
    end
    cyc(1, 0, 0, 12'h000);
    tests++;
    if (we_a !== 1'b0 || w_address !== 3'd0) begin
      failed++; $display("FAIL single_hold: we=%b addr=%0d, required we=0 addr=0", we_a, w_address);
    end
    cyc(0, 0, 0, 12'h000);
  endtask

  task automatic test_full_frame();
    int writes = 0;
    int fd_seen = 0;
    cyc(1, 1, 0, 12'h000);
    for (int k = 1; k <= 8; k++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cyc(1, 0, 0, 12'h000);
        tests++;
        if (we_a !== 1'b0) begin
          failed++; $display("FAIL frame_gap: we=%b during gap, required 0", we_a);
        end
      end
      cyc(1, 0, 1, 12'(k));
      if (we_a === 1'b1) writes++;
      if (k % 2 == 0) begin
        logic [23:0] exp_d;
        exp_d = {12'(k - 1), 12'(k)};
        tests++;
        if (we_a !== 1'b1 || w_address !== 3'(k / 2 - 1) || w_data !== exp_d) begin
          failed++;
          $display("FAIL frame_word%0d: we=%b addr=%0d data=%h, required 1 %0d %h",
                   k / 2 - 1, we_a, w_address, w_data, k / 2 - 1, exp_d);
        end
      end
    end
    cyc(1, 0, 0, 12'h000);
    if (we_a === 1'b1) writes++;
    fd_seen += int'(frame_done);
    tests++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      failed++; $display("FAIL frame_done: fd=%b busy=%b, required fd=1 busy=0", frame_done, busy);
    end
    cyc(1, 0, 1, 12'hFFF);
    if (we_a === 1'b1) writes++;
    fd_seen += int'(frame_done);
    cyc(1, 0, 1, 12'hEEE);
    if (we_a === 1'b1) writes++;
    fd_seen += int'(frame_done);
    tests++;
    if (writes !== 4 || fd_seen !== 1) begin
      failed++; $display("FAIL frame_counts: writes=%0d fd=%0d, required 4 and 1", writes, fd_seen);
    end
  endtask

  task automatic test_resync();
    cyc(1, 1, 0, 12'h000);
    cyc(1, 0, 1, 12'h001);
    cyc(1, 0, 1, 12'h002);
    cyc(1, 0, 1, 12'h003);
    cyc(1, 1, 1, 12'hCCC);
    tests++;
    if (resync_err !== 1'b1 || busy !== 1'b1 || we_a !== 1'b0) begin
      failed++;
      $display("FAIL resync_flag: rerr=%b busy=%b we=%b, required 1 1 0", resync_err, busy, we_a);
    end
    cyc(1, 0, 1, 12'hAAA);
    tests++;
    if (we_a !== 1'b0) begin
      failed++; $display("FAIL resync_half: we=%b, required 0", we_a);
    end
    cyc(1, 0, 1, 12'hBBB);
    tests++;
    if (we_a !== 1'b1 || w_address !== 3'd0 || w_data !== 24'hAAABBB || resync_err !== 1'b1) begin
      failed++;
      $display("FAIL resync_write: we=%b addr=%0d data=%h rerr=%b, required 1 0 aaabbb 1",
               we_a, w_address, w_data, resync_err);
    end
    cyc(0, 0, 0, 12'h000);
    tests++;
    if (resync_err !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL resync_clear: rerr=%b busy=%b, required 0 0", resync_err, busy);
    end
  endtask

  task automatic test_capture_drop();
    int bad = 0;
    cyc(1, 1, 0, 12'h000);
    cyc(1, 0, 1, 12'h111);
    cyc(1, 0, 1, 12'h222);
    cyc(1, 0, 1, 12'h333);
    cyc(0, 0, 0, 12'h000);
    tests++;
    if (busy !== 1'b0 || we_a !== 1'b0 || frame_done !== 1'b0) begin
      failed++;
      $display("FAIL drop_idle: busy=%b we=%b fd=%b, required 0 0 0", busy, we_a, frame_done);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(i >= 3, 0, 1, 12'(12'h400 + i));
      if (we_a !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      failed++; $display("FAIL drop_nowrite: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    cyc(1, 1, 0, 12'h000);
    cyc(1, 0, 1, 12'h0AB);
    cyc(1, 0, 1, 12'h0CD);
    tests++;
    if (we_a !== 1'b1 || w_data !== 24'h0AB0CD) begin
      failed++; $display("FAIL areset_pre: we=%b data=%h, required 1 0ab0cd", we_a, w_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({we_a, w_address, w_data, frame_done, resync_err, busy} !== '0) begin
      failed++;
      $display("FAIL areset_now: we=%b addr=%0d data=%h fd=%b rerr=%b busy=%b, all required 0",
               we_a, w_address, w_data, frame_done, resync_err, busy);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 1, 12'(12'h700 + i));
      if (we_a !== 1'b0 || busy !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin
      failed++; $display("FAIL areset_after: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_sof_final();
    cyc(1, 1, 0, 12'h000);
    for (int k = 1; k <= 7; k++) cyc(1, 0, 1, 12'(12'h010 + k));
    cyc(1, 1, 1, 12'h018);
    tests++;
    if (we_a !== 1'b1 || w_address !== 3'd3 || w_data !== 24'h017018 || resync_err !== 1'b0) begin
      failed++;
      $display("FAIL soffinal_write: we=%b addr=%0d data=%h rerr=%b, required 1 3 017018 0",
               we_a, w_address, w_data, resync_err);
    end
    cyc(1, 0, 0, 12'h000);
    tests++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || resync_err !== 1'b0) begin
      failed++;
      $display("FAIL soffinal_done: fd=%b busy=%b rerr=%b, required 1 0 0", frame_done, busy, resync_err);
    end
    cyc(1, 0, 1, 12'h055);
    cyc(1, 0, 1, 12'h066);
    tests++;
    if (we_a !== 1'b0 || busy !== 1'b0) begin
      failed++; $display("FAIL soffinal_idle: we=%b busy=%b, required 0 0", we_a, busy);
    end
  endtask

  // Model: a frame is a list of pixels; every second pixel emits one word.
  task automatic test_random();
    logic        cap = 1'b0, fin = 1'b0, rerr = 1'b0;
    logic [11:0] q[$];
    int          words = 0;
    logic        e_we, e_fd;
    logic [AW-1:0] e_addr = '0;
    logic [23:0] e_data = '0;
    logic        e, s, v;
    logic [11:0] d;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      e = ($urandom_range(0, 99) < 95);
      s = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 99) < 70);
      d = 12'($urandom);
      e_we = 1'b0;
      e_fd = 1'b0;
      if (!e) rerr = 1'b0;
      if (fin) begin
        fin  = 1'b0;
        e_fd = 1'b1;
      end else if (!cap) begin
        if (s && e) begin
          cap = 1'b1; words = 0; q.delete();
        end
      end else if (!e) begin
        cap = 1'b0; q.delete();
      end else if (v && q.size() == 1 && words == FW - 1) begin
        e_we = 1'b1; e_addr = AW'(words); e_data = {q[0], d};
        q.delete(); cap = 1'b0; fin = 1'b1;
      end else if (s) begin
        rerr = 1'b1; words = 0; q.delete();
      end else if (v) begin
        q.push_back(d);
        if (q.size() == 2) begin
          e_we = 1'b1; e_addr = AW'(words); e_data = {q[0], q[1]};
          words++; q.delete();
        end
      end
      cyc(e, s, v, d);
      tests++;
      if ({we_a, w_address, w_data, frame_done, resync_err, busy} !==
          {e_we, e_addr, e_data, e_fd, rerr, cap | fin}) begin
        failed++;
        $display("FAIL random cyc%0d: got we=%b addr=%0d data=%h fd=%b rerr=%b busy=%b, required %b %0d %h %b %b %b",
                 n, we_a, w_address, w_data, frame_done, resync_err, busy,
                 e_we, e_addr, e_data, e_fd, rerr, cap | fin);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_frame();
    test_resync();
    test_capture_drop();
    test_async_reset();
    test_sof_final();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
